ram_copy_engine: RTL
====================

// Module: ram_copy_engine
// PURPOSE
//  Initiator-side master for the single-port synchronous RAM: copies a block of LEN words
//  from SRC to DST inside that RAM without processor involvement. Drives the RAM's
//  wEn/addr/dataIn ports and consumes its registered dataOut (1-cycle read latency; dataOut
//  only updates on non-write cycles). Sits beside the processor's memory port; a top-level
//  mux grants it the RAM while busy=1.
// PARAMETERS
//  DATA_WIDTH     32    RAM word width
//  ADDRESS_WIDTH  12    RAM address width; all address arithmetic is modulo 2^ADDRESS_WIDTH
//  DEPTH          4096  RAM words; max copy length
// PORTS
//  clk          in   1     clock; all state changes on posedge
//  reset_n      in   1     synchronous, active-low reset
//  start        in   1     copy request; sampled only in IDLE
//  src_addr     in   AW    source base address, captured on accepted start
//  dst_addr     in   AW    destination base address, captured on accepted start
//  len          in   AW+1  word count, captured on accepted start; values > DEPTH saturate to DEPTH
//  abort        in   1     stop copy after current cycle
//  busy         out  1     1 in RD/WR states
//  done         out  1     1-cycle pulse at end of every accepted request (incl. len=0, abort)
//  aborted      out  1     valid with done; 1 if request ended by abort
//  words_done   out  AW+1  words written so far for current/last request; held until next start
//  ram_wEn      out  1     RAM write enable
//  ram_addr     out  AW    RAM address
//  ram_dataIn   out  DW    RAM write data
//  ram_dataOut  in   DW    RAM registered read data
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE; busy, done, aborted, words_done, ram_wEn, ram_addr,
//   ram_dataIn all 0 next cycle. Reset mid-copy: no RAM write in any cycle after the reset edge.
//  States IDLE, RD, WR, DONE.
//  IDLE: start=1 -> captures src/dst/len, clears words_done, aborted; len=0 -> DONE, else RD.
//  Direction: desc=1 iff dst!=src and ((dst-src) mod 2^AW) < len (overlap, memmove-safe);
//   asc: offset k runs 0..len-1; desc: len-1..0. Fixed for the whole request.
//  RD: ram_wEn=0, ram_addr=src+k. Next: WR (abort=1 -> DONE).
//  WR: ram_wEn=1, ram_addr=dst+k, ram_dataIn=ram_dataOut (combinational pass-through; value
//   read in preceding RD). This cycle's write always completes, even with abort=1.
//   At edge: words_done+=1; if last offset or abort -> DONE, else RD with next k.
//  DONE: done=1 for exactly one cycle, busy=0, aborted=1 if abort ended it; -> IDLE. start
//   ignored in DONE, RD, WR (no queueing).
//  Outside WR: ram_wEn=0, ram_dataIn=0; ram_addr=0 in IDLE/DONE.
//  Throughput 2 cycles/word: start edge -> done high 2*len+1 cycles later; len=0 -> next cycle.
//  Abort in RD: no write for that word; abort sampled in IDLE/DONE has no effect.
//  Address wrap: src+k, dst+k wrap past DEPTH-1 to 0 silently.
// TESTING
//  1 Reset: mem[0..3]=0..3; start src=0 dst=8 len=4 -> mem[8..11]=0..3, busy 8 cycles,
//    done 1 cycle, words_done=4, aborted=0; mem[0..3] unchanged.
//  2 Overlap fwd: mem[10..14]=A..E; src=10 dst=12 len=5 -> desc order; mem[12..16]=A..E,
//    first write addr 16, last addr 12.
//  3 Overlap back: mem[20..23]=1..4; src=20 dst=18 len=4 -> asc; mem[18..21]=1..4.
//  4 Wrap + len=0: src=4094 dst=100 len=4 -> reads 4094,4095,0,1; len=0 -> done next cycle,
//    no ram_wEn pulse.
//  5 Abort: len=10, abort during 3rd WR -> 3 words written, done+aborted, words_done=3;
//    start asserted while busy ignored.
//  6 reset_n=0 during WR of word 2 -> ram_wEn=0 every later cycle, all outputs 0.

Source files
------------

// File: rtl/ram_copy_engine.sv
// Block-copy master for a single-port synchronous RAM: one read, then one write per word.
// Copies run descending when the destination overlaps ahead of the source (memmove-safe).
module ram_copy_engine #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] src_addr,
  input  logic [ADDRESS_WIDTH-1:0] dst_addr,
  input  logic [ADDRESS_WIDTH:0]   len,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [ADDRESS_WIDTH:0]   words_done,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut
);
  localparam int AW = ADDRESS_WIDTH;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, state_nx;

  logic [AW-1:0] src_r, dst_r, k_r, end_k;
  logic          desc_r;
  logic [AW:0]   len_sat;
  logic [AW-1:0] diff, len_m1;
  logic          go_desc, last_k;

  assign len_sat = (len > DEPTH_L) ? DEPTH_L : len;
  assign diff    = dst_addr - src_addr;
  // Destination ahead of source within the block: copy from the top down.
  assign go_desc = (dst_addr != src_addr) && ({1'b0, diff} < len_sat);
  assign len_m1  = len_sat[AW-1:0] - 1'b1;
  assign last_k  = (k_r == end_k);
  assign done    = (state == DONE);

  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    ram_wEn    = 1'b0;
    ram_addr   = '0;
    ram_dataIn = '0;
    case (state)
      IDLE: if (start) state_nx = (len_sat == '0) ? DONE : RD;
      RD: begin
        busy     = 1'b1;
        ram_addr = src_r + k_r;
        state_nx = abort ? DONE : WR;
      end
      WR: begin
        busy       = 1'b1;
        ram_wEn    = 1'b1;
        ram_addr   = dst_r + k_r;
        ram_dataIn = ram_dataOut;
        state_nx   = (abort || last_k) ? DONE : RD;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      src_r      <= '0;
      dst_r      <= '0;
      k_r        <= '0;
      end_k      <= '0;
      desc_r     <= 1'b0;
      aborted    <= 1'b0;
      words_done <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          src_r      <= src_addr;
          dst_r      <= dst_addr;
          desc_r     <= go_desc;
          k_r        <= go_desc ? len_m1 : '0;
          end_k      <= go_desc ? '0 : len_m1;
          words_done <= '0;
          aborted    <= 1'b0;
        end
        RD: if (abort) aborted <= 1'b1;
        WR: begin
          words_done <= words_done + 1'b1;
          aborted    <= abort;
          k_r        <= desc_r ? k_r - 1'b1 : k_r + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
